// File: rtl/oled_i2c_responder.sv
// Write-only I2C responder modelling the SSD1306 display side: decodes control/payload bytes,
// emits command/data strobes and tracks the GDDRAM column/page pointer (horizontal mode).
module oled_i2c_responder #(
  parameter logic [6:0]  CHIP_ADDR = 7'h3C,
  parameter int unsigned NUM_COLS  = 128,
  parameter int unsigned NUM_PAGES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oen,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       data_valid,
  output logic [7:0] data_byte,
  output logic [6:0] col,
  output logic [2:0] page
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StCtrl, StCtrlAck, StPayload, StPayloadAck, StIgnore
  } state_e;

  typedef enum logic [2:0] {
    ArgNone, ArgColStart, ArgColEnd, ArgPageStart, ArgPageEnd
  } arg_e;

  localparam logic [6:0] ColEndRst  = 7'(NUM_COLS - 1);
  localparam logic [2:0] PageEndRst = 3'(NUM_PAGES - 1);

  // Synchronizers are left unreset so a reset can never fabricate a START/STOP edge.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[0], scl_in};
    sda_sync_q <= {sda_sync_q[0], sda_in};
    scl_hist_q <= scl_sync_q[1];
    sda_hist_q <= sda_sync_q[1];
  end

  logic scl, sda, scl_rise, scl_fall, start, stop;
  assign scl      = scl_sync_q[1];
  assign sda      = sda_sync_q[1];
  assign scl_rise = scl & ~scl_hist_q;
  assign scl_fall = ~scl & scl_hist_q;
  assign start    = scl & scl_hist_q & sda_hist_q & ~sda;
  assign stop     = scl & scl_hist_q & ~sda_hist_q & sda;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       ack_on_q, ack_on_d;
  logic       co_q, co_d, dc_q, dc_d;
  logic       sda_oen_q, sda_oen_d;
  logic       cmd_valid_q, cmd_valid_d, data_valid_q, data_valid_d;
  logic [7:0] cmd_byte_q, cmd_byte_d, data_byte_q, data_byte_d;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte = {shift_q, sda};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ack_on_d     = ack_on_q;
    co_d         = co_q;
    dc_d         = dc_q;
    sda_oen_d    = sda_oen_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    data_byte_d  = data_byte_q;
    byte_done    = 1'b0;

    if (scl_rise && (state_q == StAddr || state_q == StCtrl || state_q == StPayload)) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    unique case (state_q)
      StAddr: begin
        if (byte_done) begin
          if (rx_byte[7:1] == CHIP_ADDR && !rx_byte[0]) begin
            state_d  = StAddrAck;
            ack_on_d = 1'b0;
          end else begin
            state_d = StIgnore;
          end
        end
      end
      StCtrl: begin
        if (byte_done) begin
          co_d     = rx_byte[7];
          dc_d     = rx_byte[6];
          state_d  = StCtrlAck;
          ack_on_d = 1'b0;
        end
      end
      StPayload: begin
        if (byte_done) begin
          if (dc_q) begin
            data_valid_d = 1'b1;
            data_byte_d  = rx_byte;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx_byte;
          end
          state_d  = StPayloadAck;
          ack_on_d = 1'b0;
        end
      end
      StAddrAck, StCtrlAck, StPayloadAck: begin
        // First SCL fall pulls SDA for the ACK clock; the second releases it.
        if (scl_fall) begin
          if (!ack_on_q) begin
            ack_on_d  = 1'b1;
            sda_oen_d = 1'b0;
          end else begin
            ack_on_d  = 1'b0;
            sda_oen_d = 1'b1;
            if (state_q == StAddrAck)      state_d = StCtrl;
            else if (state_q == StCtrlAck) state_d = StPayload;
            else                           state_d = co_q ? StCtrl : StPayload;
          end
        end
      end
      default: ;
    endcase

    if (start || stop) begin
      state_d   = start ? StAddr : StIdle;
      bit_cnt_d = 3'd0;
      ack_on_d  = 1'b0;
      sda_oen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      ack_on_q     <= 1'b0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      sda_oen_q    <= 1'b1;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      cmd_byte_q   <= 8'd0;
      data_byte_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ack_on_q     <= ack_on_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      sda_oen_q    <= sda_oen_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      data_byte_q  <= data_byte_d;
    end
  end

  // GDDRAM window and write pointer; the pointer advances the clk after each data strobe.
  arg_e       arg_q, arg_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [2:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;

  always_comb begin
    arg_d        = arg_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_d        = col_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_d       = page_q;

    if (cmd_valid_q) begin
      unique case (arg_q)
        ArgNone: begin
          if (cmd_byte_q == 8'h21)      arg_d = ArgColStart;
          else if (cmd_byte_q == 8'h22) arg_d = ArgPageStart;
        end
        ArgColStart: begin
          col_start_d = cmd_byte_q[6:0];
          arg_d       = ArgColEnd;
        end
        ArgColEnd: begin
          col_end_d = cmd_byte_q[6:0];
          col_d     = col_start_q;
          arg_d     = ArgNone;
        end
        ArgPageStart: begin
          page_start_d = cmd_byte_q[2:0];
          arg_d        = ArgPageEnd;
        end
        ArgPageEnd: begin
          page_end_d = cmd_byte_q[2:0];
          page_d     = page_start_q;
          arg_d      = ArgNone;
        end
        default: arg_d = ArgNone;
      endcase
    end

    if (data_valid_q) begin
      if (col_q == col_end_q) begin
        col_d  = col_start_q;
        page_d = (page_q == page_end_q) ? page_start_q : page_q + 3'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end

    if (start || stop) arg_d = ArgNone;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arg_q        <= ArgNone;
      col_start_q  <= 7'd0;
      col_end_q    <= ColEndRst;
      col_q        <= 7'd0;
      page_start_q <= 3'd0;
      page_end_q   <= PageEndRst;
      page_q       <= 3'd0;
    end else begin
      arg_q        <= arg_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_q        <= col_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_q       <= page_d;
    end
  end

  assign sda_oen    = sda_oen_q;
  assign busy       = (state_q == StAddrAck) || (state_q == StCtrl) || (state_q == StCtrlAck) ||
                      (state_q == StPayload) || (state_q == StPayloadAck);
  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign data_valid = data_valid_q;
  assign data_byte  = data_byte_q;
  assign col        = col_q;
  assign page       = page_q;

endmodule
